// File: rtl/rng_pkg.sv
// Shared types and constants for the rng16 sequencer: FSM states, seed constants and the seed filter.
package rng_pkg;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    WARMUP = 2'd1,
    RUN    = 2'd2
  } rng_state_e;

  localparam logic [31:0] RNG_DEFAULT_SEED = 32'hACE1_2468;
  localparam logic [31:0] RNG_BAD_SEED     = 32'hFFFF_FFFF;

  // All-zero locks rng1; all-ones locks rng2, which is loaded with the inverted seed.
  function automatic logic [31:0] seed_fix(input logic [31:0] s, input logic [31:0] dflt);
    return ((s == 32'h0000_0000) || (s == RNG_BAD_SEED)) ? dflt : s;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the search starts one past i_pointer and wraps modulo N.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         i_eligible,
  input  logic [$clog2(N)-1:0] i_pointer,
  output logic [N-1:0]         o_grant,
  output logic [$clog2(N)-1:0] o_index,
  output logic                 o_valid
);

  localparam int IW = $clog2(N);

  logic [IW-1:0] w_cand;

  always_comb begin
    o_grant = '0;
    o_index = '0;
    o_valid = 1'b0;
    w_cand  = '0;
    for (int i = 1; i <= N; i++) begin
      w_cand = IW'((int'(i_pointer) + i) % N);
      if (!o_valid && i_eligible[w_cand]) begin
        o_valid          = 1'b1;
        o_grant[w_cand]  = 1'b1;
        o_index          = w_cand;
      end
    end
  end

endmodule

// File: rtl/rng_sched.sv
// Load/warm-up/run sequencer and round-robin arbiter sharing one rng16 word stream among N_REQ consumers.
// Define RNG_SCHED_STATS_EN to add the saturating grant counter output stat_grants.
module rng_sched
  import rng_pkg::*;
#(
  parameter int          N_REQ         = 4,
  parameter int          WARMUP_CYCLES = 32,
  parameter logic [31:0] DEFAULT_SEED  = RNG_DEFAULT_SEED
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      seed_in,
  input  logic             reseed_req,
  output logic             busy,
  output logic [31:0]      rng_seed,
  output logic             rng_load,
  input  logic [15:0]      rng_rnd1,
  input  logic [15:0]      rng_rnd2,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [15:0]      rnd_a,
  output logic [15:0]      rnd_b
`ifdef RNG_SCHED_STATS_EN
  ,
  output logic [31:0]      stat_grants
`endif
);

  localparam int            IW       = $clog2(N_REQ);
  localparam int            CW       = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'((WARMUP_CYCLES > 0) ? WARMUP_CYCLES - 1 : 0);

  rng_state_e       r_state;
  rng_state_e       w_next;
  logic [CW-1:0]    r_cnt;
  logic [31:0]      r_seed;
  logic [N_REQ-1:0] r_gnt;
  logic [IW-1:0]    r_ptr;
  logic [15:0]      r_rnd_a;
  logic [15:0]      r_rnd_b;
  logic [N_REQ-1:0] w_grant;
  logic [IW-1:0]    w_index;
  logic             w_valid;
  logic             w_take;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= LOAD;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (reseed_req) begin
      w_next = LOAD;
    end else begin
      case (r_state)
        LOAD:    w_next = (WARMUP_CYCLES == 0) ? RUN : WARMUP;
        WARMUP:  if (r_cnt == LAST_CNT) w_next = RUN;
        RUN:     w_next = RUN;
        default: w_next = LOAD;
      endcase
    end
  end

  always_comb begin
    busy     = (r_state != RUN);
    rng_load = (r_state == LOAD);
  end

  // Warm-up counter only runs inside WARMUP; any reseed clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt  <= '0;
      r_seed <= DEFAULT_SEED;
    end else begin
      if ((r_state == WARMUP) && !reseed_req) r_cnt <= r_cnt + 1'b1;
      else                                    r_cnt <= '0;
      if (reseed_req) r_seed <= seed_fix(seed_in, DEFAULT_SEED);
    end
  end

  rr_arbiter #(.N(N_REQ)) u_arb (
    .i_eligible (req & ~r_gnt),
    .i_pointer  (r_ptr),
    .o_grant    (w_grant),
    .o_index    (w_index),
    .o_valid    (w_valid)
  );

  assign w_take = (r_state == RUN) && !reseed_req && w_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_gnt   <= '0;
      r_ptr   <= IW'(N_REQ - 1);
      r_rnd_a <= '0;
      r_rnd_b <= '0;
    end else begin
      r_gnt <= w_take ? w_grant : '0;
      if (w_take) begin
        r_ptr   <= w_index;
        r_rnd_a <= rng_rnd1;
        r_rnd_b <= rng_rnd2;
      end
    end
  end

  assign gnt      = r_gnt;
  assign rnd_a    = r_rnd_a;
  assign rnd_b    = r_rnd_b;
  assign rng_seed = r_seed;

`ifdef RNG_SCHED_STATS_EN
  logic [31:0] r_stat;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                r_stat <= '0;
    else if (w_next == LOAD)                  r_stat <= '0;
    else if (w_take && (r_stat != 32'hFFFF_FFFF)) r_stat <= r_stat + 32'd1;
  end

  assign stat_grants = r_stat;
`endif

endmodule

// File: tb/tb_rng_sched.sv
// Bench for rng_sched: table-driven corner cases plus randomized traffic against a behavioural model.
module tb_rng_sched;

  localparam int          N     = 4;
  localparam int          W     = 32;
  localparam logic [31:0] DSEED = 32'hACE1_2468;

  logic          clk = 1'b0;
  logic          reset;
  logic [31:0]   seed_in;
  logic          reseed_req;
  logic          busy;
  logic [31:0]   rng_seed;
  logic          rng_load;
  logic [15:0]   rng_rnd1;
  logic [15:0]   rng_rnd2;
  logic [N-1:0]  req;
  logic [N-1:0]  gnt;
  logic [15:0]   rnd_a;
  logic [15:0]   rnd_b;
`ifdef RNG_SCHED_STATS_EN
  logic [31:0]   stat_grants;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  rng_sched #(.N_REQ(N), .WARMUP_CYCLES(W), .DEFAULT_SEED(DSEED)) dut (
    .clk        (clk),
    .reset      (reset),
    .seed_in    (seed_in),
    .reseed_req (reseed_req),
    .busy       (busy),
    .rng_seed   (rng_seed),
    .rng_load   (rng_load),
    .rng_rnd1   (rng_rnd1),
    .rng_rnd2   (rng_rnd2),
    .req        (req),
    .gnt        (gnt),
    .rnd_a      (rnd_a),
    .rnd_b      (rnd_b)
`ifdef RNG_SCHED_STATS_EN
    ,
    .stat_grants(stat_grants)
`endif
  );

  // Behavioural model: busy lasts 1+W clocks after each load; one grant per clock in round-robin order.
  int           m_left;
  logic [31:0]  m_seed;
  logic [N-1:0] m_gnt;
  logic [15:0]  m_a;
  logic [15:0]  m_b;
  int           m_ptr;
  longint       m_stat;

  function automatic void m_reset();
    m_left = 1 + W;
    m_seed = DSEED;
    m_gnt  = '0;
    m_a    = '0;
    m_b    = '0;
    m_ptr  = N - 1;
    m_stat = 0;
  endfunction

  function automatic void m_edge();
    logic [N-1:0] elig;
    bit           run;
    run   = (m_left == 0);
    elig  = req & ~m_gnt;
    m_gnt = '0;
    if (run && !reseed_req) begin
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (m_gnt == '0 && elig[c]) begin
          m_gnt[c] = 1'b1;
          m_ptr    = c;
          m_a      = rng_rnd1;
          m_b      = rng_rnd2;
          m_stat   = m_stat + 1;
        end
      end
    end
    if (reseed_req) begin
      m_left = 1 + W;
      m_seed = (seed_in == 32'h0 || seed_in == 32'hFFFF_FFFF) ? DSEED : seed_in;
      m_stat = 0;
    end else if (m_left > 0) begin
      m_left = m_left - 1;
    end
  endfunction

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endfunction

  function automatic void check_all();
    chk("busy",     32'(busy),     32'(m_left > 0));
    chk("rng_load", 32'(rng_load), 32'(m_left == 1 + W));
    chk("gnt",      32'(gnt),      32'(m_gnt));
    chk("rnd_a",    32'(rnd_a),    32'(m_a));
    chk("rnd_b",    32'(rnd_b),    32'(m_b));
    chk("rng_seed", rng_seed,      m_seed);
`ifdef RNG_SCHED_STATS_EN
    chk("stat_grants", stat_grants, m_stat[31:0]);
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    m_edge();
    #1;
    check_all();
    rng_rnd1 = 16'($urandom);
    rng_rnd2 = 16'($urandom);
  endtask

  task automatic wait_run(input string tag);
    int g;
    g = 0;
    while (busy && g < 200) begin
      tick();
      g++;
    end
    chk({tag, "_run_reached"}, 32'(busy), 32'd0);
  endtask

  typedef struct {
    logic [31:0] seed;
    logic [31:0] exp_seed;
  } seed_vec_t;

  typedef struct {
    logic [N-1:0] req;
    logic [N-1:0] exp_gnt;
  } gnt_vec_t;

  seed_vec_t seed_tab[5];
  gnt_vec_t  rr_tab[8];
  gnt_vec_t  one_tab[6];

  initial begin
    int cnt_b, cnt_l, early, g;
    logic [15:0] p1, p2;

    seed_tab[0] = '{32'h0000_0000, 32'hACE1_2468};
    seed_tab[1] = '{32'hFFFF_FFFF, 32'hACE1_2468};
    seed_tab[2] = '{32'h1234_5678, 32'h1234_5678};
    seed_tab[3] = '{32'h0000_0001, 32'h0000_0001};
    seed_tab[4] = '{32'hFFFF_FFFE, 32'hFFFF_FFFE};
    rr_tab[0] = '{4'b1111, 4'b0001};
    rr_tab[1] = '{4'b1111, 4'b0010};
    rr_tab[2] = '{4'b1111, 4'b0100};
    rr_tab[3] = '{4'b1111, 4'b1000};
    rr_tab[4] = '{4'b1111, 4'b0001};
    rr_tab[5] = '{4'b1111, 4'b0010};
    rr_tab[6] = '{4'b1111, 4'b0100};
    rr_tab[7] = '{4'b1111, 4'b1000};
    for (int i = 0; i < 6; i++) one_tab[i] = '{4'b0100, (i % 2 == 0) ? 4'b0100 : 4'b0000};

    reset      = 1'b1;
    seed_in    = '0;
    reseed_req = 1'b0;
    req        = '0;
    rng_rnd1   = 16'($urandom);
    rng_rnd2   = 16'($urandom);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy",  32'(busy),     32'd1);
    chk("rst_load",  32'(rng_load), 32'd1);
    chk("rst_gnt",   32'(gnt),      32'd0);
    chk("rst_rnd_a", 32'(rnd_a),    32'd0);
    chk("rst_rnd_b", 32'(rnd_b),    32'd0);
    chk("rst_seed",  rng_seed,      DSEED);
    m_reset();
    reset = 1'b0;

    // Bring-up with every consumer requesting: no grant may appear while busy.
    req   = 4'b1111;
    cnt_b = int'(busy);
    cnt_l = int'(rng_load);
    early = 0;
    g     = 0;
    while (busy && g < 100) begin
      tick();
      g++;
      if (busy) cnt_b++;
      if (rng_load) cnt_l++;
      if (busy && gnt != '0) early++;
    end
    chk("bringup_busy_clks", 32'(cnt_b), 32'd33);
    chk("bringup_load_clks", 32'(cnt_l), 32'd1);
    chk("bringup_early_gnt", 32'(early), 32'd0);

    for (int i = 0; i < 8; i++) begin
      req = rr_tab[i].req;
      p1  = rng_rnd1;
      p2  = rng_rnd2;
      tick();
      chk("rr_all_gnt", 32'(gnt),   32'(rr_tab[i].exp_gnt));
      chk("rr_all_a",   32'(rnd_a), 32'(p1));
      chk("rr_all_b",   32'(rnd_b), 32'(p2));
    end

    // Asynchronous reset between edges while a grant is showing.
    #2;
    reset = 1'b1;
    #1;
    chk("async_gnt",   32'(gnt),      32'd0);
    chk("async_busy",  32'(busy),     32'd1);
    chk("async_load",  32'(rng_load), 32'd1);
    chk("async_rnd_a", 32'(rnd_a),    32'd0);
    chk("async_seed",  rng_seed,      DSEED);
    m_reset();
    req = '0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    wait_run("after_async");

    for (int i = 0; i < 6; i++) begin
      req = one_tab[i].req;
      tick();
      chk("single_req2_gnt", 32'(gnt), 32'(one_tab[i].exp_gnt));
    end

    req = '0;
    for (int i = 0; i < 5; i++) begin
      seed_in    = seed_tab[i].seed;
      reseed_req = 1'b1;
      tick();
      reseed_req = 1'b0;
      chk("seed_fix", rng_seed, seed_tab[i].exp_seed);
    end
    wait_run("after_seeds");

    // Reseed collides with requests in RUN; the RR pointer must survive the reload.
    req = 4'b0001;
    tick();
    chk("ptr_setup_gnt", 32'(gnt), 32'b0001);
    req = '0;
    tick();
    req        = 4'b0011;
    seed_in    = 32'h0BAD_F00D;
    reseed_req = 1'b1;
    tick();
    reseed_req = 1'b0;
    chk("collide_gnt",  32'(gnt),      32'd0);
    chk("collide_load", 32'(rng_load), 32'd1);
    chk("collide_busy", 32'(busy),     32'd1);
    wait_run("collide");
    tick();
    chk("resume_gnt0", 32'(gnt), 32'b0010);
    tick();
    chk("resume_gnt1", 32'(gnt), 32'b0001);

    // Reseed in warm-up cycle 10 restarts the whole load/warm-up sequence.
    req        = '0;
    seed_in    = 32'h5555_AAAA;
    reseed_req = 1'b1;
    tick();
    reseed_req = 1'b0;
    req        = 4'b1111;
    repeat (10) tick();
    seed_in    = 32'h1234_5678;
    reseed_req = 1'b1;
    tick();
    reseed_req = 1'b0;
`ifdef RNG_SCHED_STATS_EN
    chk("warm_reseed_stats", stat_grants, 32'd0);
`endif
    chk("warm_reseed_seed", rng_seed, 32'h1234_5678);
    cnt_b = int'(busy);
    g     = 0;
    while (busy && g < 100) begin
      tick();
      g++;
      if (busy) cnt_b++;
    end
    chk("warm_reseed_busy_clks", 32'(cnt_b), 32'd33);

    for (int i = 0; i < 3000; i++) begin
      req        = N'($urandom);
      reseed_req = ($urandom_range(0, 99) == 0);
      case ($urandom_range(0, 3))
        0:       seed_in = 32'h0;
        1:       seed_in = 32'hFFFF_FFFF;
        default: seed_in = $urandom;
      endcase
      tick();
    end
    reseed_req = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
